// File: rtl/slow_input_sync.sv
// Multi-channel synchroniser and debouncer for slow asynchronous inputs.
// Each channel: SYNC_STAGES flop chain, then a stability counter gating a registered level and edge strobes.
module slow_input_sync #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      SYNC_STAGES     = 2,
  parameter int unsigned      DEBOUNCE_CYCLES = 8,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] out_q,  out_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  // Metastability chain; only stage 0 sees the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= RESET_VAL;
      end
    end else begin
      sync_q[0] <= in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // A level is accepted only after DEBOUNCE_CYCLES consecutive mismatches; any match restarts the count.
  always_comb begin
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sync_s[i] == out_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        out_d[i]  = sync_s[i];
        rise_d[i] = sync_s[i];
        fall_d[i] = ~sync_s[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: tb/tb_slow_input_sync.sv
// Bench for slow_input_sync: history-window reference model feeding a scoreboard queue,
// plus directed latency checks measured from the cycle each input change is driven.
module tb_slow_input_sync;

  localparam int unsigned W  = 4;
  localparam int unsigned S  = 2;
  localparam int unsigned D  = 8;
  localparam int unsigned H  = S + D - 1;
  localparam logic [W-1:0] RV = '0;

  typedef struct packed {
    logic [W-1:0] out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout, drise, dfall;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int popped = 0;
  int rise_n [W];
  int fall_n [W];
  int last_rise_cyc [W];
  int last_fall_cyc [W];

  exp_t         sb_q [$];
  logic [W-1:0] hist [H];
  logic [W-1:0] m_out;

  slow_input_sync #(
    .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .RESET_VAL(RV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .in  (din),
    .out (dout),
    .rise(drise),
    .fall(dfall)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: out[c] flips once the last D synchronised samples all differ from it.
  always @(posedge clk or posedge rst) begin
    exp_t e;
    logic all_diff;
    if (rst) begin
      for (int k = 0; k < int'(H); k++) hist[k] = RV;
      m_out = RV;
      sb_q.delete();
      e.out = RV; e.rise = '0; e.fall = '0;
      sb_q.push_back(e);
    end else begin
      e.rise = '0;
      e.fall = '0;
      for (int c = 0; c < int'(W); c++) begin
        all_diff = 1'b1;
        for (int k = int'(S) - 1; k < int'(H); k++) begin
          if (hist[k][c] == m_out[c]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_out[c] = ~m_out[c];
          if (m_out[c]) e.rise[c] = 1'b1;
          else          e.fall[c] = 1'b1;
        end
      end
      for (int k = int'(H) - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = din;
      e.out = m_out;
      sb_q.push_back(e);
    end
  end

  // Scoreboard pop and strobe bookkeeping away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      popped++;
      check("out",  32'(dout),  32'(e.out));
      check("rise", 32'(drise), 32'(e.rise));
      check("fall", 32'(dfall), 32'(e.fall));
    end
    for (int c = 0; c < int'(W); c++) begin
      if (drise[c]) begin rise_n[c]++; last_rise_cyc[c] = cyc; end
      if (dfall[c]) begin fall_n[c]++; last_fall_cyc[c] = cyc; end
    end
  end

  initial begin
    int c0, c1, r1, r2, r3;
    for (int c = 0; c < int'(W); c++) begin
      rise_n[c] = 0; fall_n[c] = 0; last_rise_cyc[c] = -1; last_fall_cyc[c] = -1;
    end

    // Reset with all inputs high, then release.
    din = 4'hF;
    #1 rst = 1'b1;
    tick(2);
    rst = 1'b0;
    c0 = cyc;
    tick(14);
    check("rst_rise_lat0", 32'(last_rise_cyc[0] - c0), 32'd10);
    check("rst_rise_lat3", 32'(last_rise_cyc[3] - c0), 32'd10);
    check("rst_rise_cnt0", 32'(rise_n[0]), 32'd1);
    din = 4'h0;
    c0 = cyc;
    tick(14);
    check("all_fall_lat1", 32'(last_fall_cyc[1] - c0), 32'd10);

    // Clean edge on channel 0.
    din[0] = 1'b1;
    c0 = cyc;
    tick(14);
    check("clean_rise_lat", 32'(last_rise_cyc[0] - c0), 32'd10);
    check("clean_quiet1", 32'(rise_n[1]), 32'd1);
    din[0] = 1'b0;
    c0 = cyc;
    tick(14);
    check("clean_fall_lat", 32'(last_fall_cyc[0] - c0), 32'd10);

    // Seven-cycle pulse is filtered, eight-cycle pulse is accepted.
    r1 = rise_n[1];
    din[1] = 1'b1;
    tick(7);
    din[1] = 1'b0;
    tick(14);
    check("bounce7_none", 32'(rise_n[1]), 32'(r1));
    din[1] = 1'b1;
    c0 = cyc;
    tick(8);
    din[1] = 1'b0;
    c1 = cyc;
    tick(14);
    check("pulse8_rise_lat", 32'(last_rise_cyc[1] - c0), 32'd10);
    check("pulse8_fall_lat", 32'(last_fall_cyc[1] - c1), 32'd10);

    // One-cycle low after four highs restarts the count.
    r2 = rise_n[2];
    din[2] = 1'b1;
    tick(4);
    din[2] = 1'b0;
    tick(1);
    din[2] = 1'b1;
    c0 = cyc;
    tick(14);
    check("chatter_rise_lat", 32'(last_rise_cyc[2] - c0), 32'd10);
    check("chatter_rise_cnt", 32'(rise_n[2]), 32'(r2 + 1));

    // Simultaneous rise on channel 2 and fall on channel 3.
    din = 4'h8;
    tick(14);
    din = 4'h4;
    c0 = cyc;
    tick(14);
    check("simul_rise_lat", 32'(last_rise_cyc[2] - c0), 32'd10);
    check("simul_fall_lat", 32'(last_fall_cyc[3] - c0), 32'd10);

    // Asynchronous reset five edges into a debounce.
    din = 4'hC;
    r3 = rise_n[3];
    tick(5);
    #3 rst = 1'b1;
    #1;
    check("midrst_out",  32'(dout),  32'(RV));
    check("midrst_rise", 32'(drise), 32'd0);
    check("midrst_fall", 32'(dfall), 32'd0);
    check("midrst_nostrobe", 32'(rise_n[3]), 32'(r3));
    tick(2);
    rst = 1'b0;
    c0 = cyc;
    tick(14);
    check("midrst_rise_lat", 32'(last_rise_cyc[3] - c0), 32'd10);

    // Random hold lengths straddling the debounce window.
    for (int n = 0; n < 60; n++) begin
      din = W'($urandom);
      tick(int'($urandom_range(1, 12)));
    end
    tick(14);
    check("sb_active", 32'(popped >= 300), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slow_input_sync.md
# slow_input_sync

Multi-channel synchroniser and debouncer for slow asynchronous inputs such as push-buttons, DIP switches and board strap or status pins. Each channel passes through a metastability synchroniser chain and a per-channel stability counter. The block presents a clean registered level plus single-cycle rise and fall strobes in the `clk` domain. It is the parametrised successor to the single-bit slow input flop and sits between the top-level pads and the capture/control logic.

## Interface
- `WIDTH`, 4: number of independent input channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `DEBOUNCE_CYCLES`, 8: consecutive cycles a new level must persist before it is accepted (≥1).
- `RESET_VAL`, {WIDTH{1'b0}}: per-channel reset level of the synchroniser chain and `out`.

- `clk`  in  1  single system clock; all state is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in`  in  WIDTH  raw asynchronous inputs.
- `out`  out  WIDTH  debounced, registered level.
- `rise`  out  WIDTH  one-cycle pulse when `out[i]` goes 0→1.
- `fall`  out  WIDTH  one-cycle pulse when `out[i]` goes 1→0.

## Operation
- Per channel i: a SYNC_STAGES-deep flop chain produces `s[i]`, the last stage.
- Per channel counter `cnt[i]` is CNT_W = clog2(DEBOUNCE_CYCLES) bits wide, with a minimum of 1 bit.
- Each rising edge, per channel:
  - if `s[i] == out[i]`: `cnt[i] <= 0`.
  - else if `cnt[i] == DEBOUNCE_CYCLES-1`: `out[i] <= s[i]`, `cnt[i] <= 0`, and `rise[i] <= s[i]` / `fall[i] <= ~s[i]`.
  - else: `cnt[i] <= cnt[i]+1`.
- `rise[i]` and `fall[i]` are 0 on every edge where `out[i]` does not update.
- They are registered and coincide with the first cycle `out[i]` shows the new value.
- `rise[i]` and `fall[i]` are never both 1.
- Any single cycle of `s[i] == out[i]` (a bounce) clears the counter. Acceptance needs DEBOUNCE_CYCLES consecutive mismatching edges.
- Channels are fully independent. Simultaneous changes on several channels update on the same edge with no arbitration.
- Reset: the asynchronous assert sets every sync stage and `out` to RESET_VAL, `cnt` to 0, and `rise`/`fall` to 0.
  - Nothing is latched during reset.
  - If `in` differs from RESET_VAL during reset, the change is debounced normally after release and produces a strobe.
- Reset asserted mid-debounce abandons the count with no strobe. Reset is held until `rst` is deasserted.
- DEBOUNCE_CYCLES = 1: no filtering. `out` follows `s` one edge later.

## Timing
- Latency: a new level stable before edge 1 (the first edge sampling it) appears on `out`, `rise` and `fall` after edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - Defaults: `out`, `rise` and `fall` are valid after edge 10, i.e. 200 ns at 50 MHz.
- Minimum accepted pulse: DEBOUNCE_CYCLES clock periods of stable level at `s`. One cycle shorter is filtered with no output activity.
- Strobe width is exactly one `clk` cycle.
- The input toggle rate is bounded only by the debounce window. A pulse shorter than DEBOUNCE_CYCLES never reaches `out`.
- `in` carries no setup/hold requirement. It must be constrained as an asynchronous path into sync stage 1 only.
- Reset deassertion is assumed synchronised to `clk` upstream. Outputs hold reset values until the first edge after release.

## Test plan
All cases use defaults (WIDTH=4, S=2, D=8) and a 20 ns clock.

- **Reset:**
  - Stimulus: `rst`=1 for 2 cycles with `in`=4'hF, then release.
  - Response: `out`=0, `rise`=`fall`=0 throughout reset. `out`=4'hF and `rise`=4'hF for exactly one cycle on edge 10 after release.
- **Clean edge:**
  - Stimulus: `in[0]` 0→1, held.
  - Response: `out[0]`=1 and `rise[0]`=1 on edge 10 only; channels 1–3 quiet. Then `in[0]` 1→0 gives `fall[0]` on edge 10.
- **Bounce filter:**
  - Stimulus: `in[1]` high for 7 cycles then low.
  - Response: `out[1]` stays 0 with no strobes.
  - Then `in[1]` high for exactly 8 cycles: `out[1]` goes 1 with `rise[1]`=1 for one cycle. 10 edges after the falling edge, `fall[1]`=1.
- **Chatter reset:**
  - Stimulus: `in[2]` toggles 1,1,1,1,0,1… (one-cycle low after 4 high).
  - Response: the counter restarts. `out[2]` rises 8 cycles after the last low sample at `s`, not earlier.
- **Simultaneous channels:**
  - Stimulus: from `out`=4'h8, `in`=4'h4 applied on one edge.
  - Response: on edge 10 `out`=4'h4, `rise`=4'h4 and `fall`=4'h8 in the same cycle.
- **Reset mid-debounce:**
  - Stimulus: `in[3]` 0→1, then `rst`=1 asynchronously 5 edges later.
  - Response: the `out` and `cnt` reset values appear immediately, with no strobe.
  - After release with `in[3]` still 1, `rise[3]` fires on edge 10 after release.
